mux_rr_sched: RTL and testbench
===============================

# mux_rr_sched

Round-robin scheduler that shares a registered 4:1 single-bit mux-and-flop datapath between four requesters. Each requester raises `req[k]` while it has data on `din[k]`; the block grants one requester at a time, drives the mux select, and registers the granted bit onto `q` with a valid qualifier. Grants are bounded by a burst limit so no requester can starve the others.

## Interface
- `MAX_BURST`, default 4: maximum data beats per grant; legal range 1..16.
- `N_REQ`, default 4: number of requesters. Fixed at 4, because `sel` is 2 bits.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high reset; sampled on `clk` rising edge.
- `req`  in  4  request per requester; held high while the requester has data.
- `din`  in  4  data bit per requester; `din[k]` is the mux input k.
- `gnt`  out  4  registered one-hot grant; all zero when idle.
- `sel`  out  2  registered mux select; equals the index of the set `gnt` bit, otherwise holds its last value.
- `q`  out  1  registered mux output.
- `q_valid`  out  1  high for one cycle per transferred beat.
- `q_src`  out  2  index of the requester whose beat is on `q`.

## Operation
- States:
  - IDLE: no owner.
  - GRANT: owner `k = sel`, with beat counter `cnt` of width clog2(MAX_BURST), minimum 1.
- Round-robin pointer `ptr`: search start index, equal to last owner + 1 mod 4.
- Winner: the first set bit of `req` scanning cyclically from the search start.
- IDLE, at each edge:
  - If `req` != 0: go to GRANT, `gnt` = onehot(winner from `ptr`), `sel` = winner, `cnt` = 0.
  - `q_valid` <= 0.
- GRANT, at each edge:
  - Beat when `req[k]` = 1: `q` <= `din[k]`, `q_src` <= k, `q_valid` <= 1, `cnt` <= `cnt` + 1.
  - No beat otherwise: `q_valid` <= 0, `q` holds.
  - Release when `req[k]` = 0, or when there is a beat and `cnt` = MAX_BURST-1.
  - On release: `ptr` <= k+1. The new winner is found from k+1 using `req` at the same edge. If there is a winner, stay in GRANT with the new owner and `cnt` = 0, with no idle gap. Otherwise go to IDLE with `gnt` = 0.
  - A sole requester whose burst expires is re-granted immediately.
- Transfers are 4-state transparent: an `x`/`z` on `din[k]` appears on `q` unchanged.
- A requester may drop `req` at any time. The edge that sees `req[k]` = 0 carries no beat.
- `req` of non-owners is ignored except when arbitrating.

## Timing
- Reset (one edge with `reset` = 1) clears everything: state to IDLE, `gnt` = 0, `sel` = 0, `q` = 0, `q_valid` = 0, `q_src` = 0, `cnt` = 0, `ptr` = 0. Reset has priority over every other event at that edge.
- Reset mid-burst: any beat at the reset edge is discarded, and the next grant searches from port 0.
- Request to grant: 1 cycle. `req` is sampled at edge N; `gnt`/`sel` are valid after edge N.
- Grant to data: 1 cycle. The beat is sampled at edge N+1, so `q`/`q_valid` are visible after N+1. First-data latency from `req` rising is 2 edges.
- Throughput: one beat per cycle, continuous across owner handoffs when requests remain.
- Arbitration is one-cycle combinational inside the block; no combinational path exists from inputs to outputs.

## Structure
- Package `mux_sched_pkg` holds:
  - state enum `sched_state_t` {IDLE, GRANT};
  - constants `N_REQ` = 4 and `SEL_W` = 2;
  - function `onehot4(idx)`.
- Sub-module `rr_pick4`, combinational: inputs `req[3:0]` and `start[1:0]`; outputs `found` and `idx[1:0]`.
- The scheduler holds the FSM, the burst counter, the pointer, and the mux/flop datapath.

## Test plan
- Reset: hold `reset` = 1 for 2 edges with `req` = 1111 and `din` = 1111 -> `gnt` = 0000, `sel` = 0, `q` = 0, `q_valid` = 0, `q_src` = 0 after each edge.
- Sole requester, MAX_BURST = 4: `req` = 0010, `din` = 0010 from reset release -> `gnt` = 0010 after edge 1. `q_valid` = 1, `q` = 1, `q_src` = 1 continuously from edge 2, with re-grant every 4 beats and no gap.
- Fairness, MAX_BURST = 2: `req` = 1111, `din` = 0101 -> owners 0,0,1,1,2,2,3,3,0 per beat. `q` = 1,1,0,0,1,1,0,0,1 and `q_valid` stays 1 throughout.
- Early drop: owner 2 with `req` = 1100 drops `req[2]` after 1 beat -> that edge has `q_valid` = 0 and `gnt` becomes 1000. `q_src` = 3 on the next beat.
- Idle and re-arbitration: after owner 3 releases, `req` = 0000 -> IDLE with `gnt` = 0000. Then `req` = 0011 -> grant 0001 (ptr = 0 wraps from 3).
- Reset mid-burst plus 4-state data: owner 1 with `din[1]` = x shows `q` = x. Asserting `reset` at beat 2 gives all outputs 0 after that edge, and with `req` = 0110 the next grant is 0010.

Source files
------------

// File: rtl/mux_sched_pkg.sv
// Shared constants, FSM state type and helpers for the round-robin mux scheduler.
package mux_sched_pkg;

    localparam int unsigned N_REQ = 4;
    localparam int unsigned SEL_W = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } sched_state_t;

    function automatic logic [N_REQ-1:0] onehot4(input logic [SEL_W-1:0] idx);
        onehot4 = N_REQ'(1) << idx;
    endfunction

endpackage

// File: rtl/rr_pick4.sv
// Cyclic first-set-bit finder: returns the first asserted req at or after start.
module rr_pick4
    import mux_sched_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] start,
    output logic             found,
    output logic [SEL_W-1:0] idx
);

    logic [SEL_W-1:0] cand;

    // Scan from the farthest offset down so the nearest requester wins last.
    always_comb begin
        found = 1'b0;
        idx   = start;
        cand  = start;
        for (int j = N_REQ - 1; j >= 0; j--) begin
            cand = start + SEL_W'(j);
            if (req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/mux_rr_sched.sv
// Round-robin scheduler sharing a registered 4:1 mux-and-flop between four requesters,
// with a per-grant burst limit and back-to-back owner handoff.
module mux_rr_sched
    import mux_sched_pkg::*;
#(
    parameter int unsigned MAX_BURST = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] din,
    output logic [N_REQ-1:0] gnt,
    output logic [SEL_W-1:0] sel,
    output logic             q,
    output logic             q_valid,
    output logic [SEL_W-1:0] q_src
);

    localparam int unsigned CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);

    sched_state_t     state;
    logic [CNT_W-1:0] cnt;
    logic [SEL_W-1:0] ptr;

    logic             beat;
    logic             handoff;
    logic [SEL_W-1:0] start;
    logic             found;
    logic [SEL_W-1:0] win;

    // Owner is sel while in GRANT; a handoff searches from the slot after it.
    always_comb begin
        beat    = 1'b0;
        handoff = 1'b0;
        start   = ptr;
        if (state == GRANT) begin
            beat    = req[sel];
            handoff = !req[sel] || (cnt == LAST_BEAT);
            start   = sel + SEL_W'(1);
        end
    end

    rr_pick4 u_pick (
        .req   (req),
        .start (start),
        .found (found),
        .idx   (win)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            gnt     <= '0;
            sel     <= '0;
            q       <= 1'b0;
            q_valid <= 1'b0;
            q_src   <= '0;
            cnt     <= '0;
            ptr     <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    q_valid <= 1'b0;
                    if (found) begin
                        state <= GRANT;
                        gnt   <= onehot4(win);
                        sel   <= win;
                        cnt   <= '0;
                    end
                end
                GRANT: begin
                    if (beat) begin
                        q       <= din[sel];
                        q_src   <= sel;
                        q_valid <= 1'b1;
                        cnt     <= cnt + CNT_W'(1);
                    end else begin
                        q_valid <= 1'b0;
                    end
                    // Handoff goes straight to the next owner when one is waiting.
                    if (handoff) begin
                        ptr <= sel + SEL_W'(1);
                        cnt <= '0;
                        if (found) begin
                            gnt <= onehot4(win);
                            sel <= win;
                        end else begin
                            state <= IDLE;
                            gnt   <= '0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mux_rr_sched.sv
// Bench for mux_rr_sched: two instances (bursts 4 and 2) checked against a per-beat model,
// plus directed vectors for reset, fairness, early drop, idle and x-propagation.
module tb_mux_rr_sched;

    logic       clk;
    logic       reset;
    logic [3:0] req;
    logic [3:0] din;

    logic [3:0] gnt4, gnt2;
    logic [1:0] sel4, sel2, src4, src2;
    logic       q4, q2, qv4, qv2;

    int checks = 0;
    int errors = 0;

    mux_rr_sched #(.MAX_BURST(4)) u4 (
        .clk(clk), .reset(reset), .req(req), .din(din),
        .gnt(gnt4), .sel(sel4), .q(q4), .q_valid(qv4), .q_src(src4)
    );

    mux_rr_sched #(.MAX_BURST(2)) u2 (
        .clk(clk), .reset(reset), .req(req), .din(din),
        .gnt(gnt2), .sel(sel2), .q(q2), .q_valid(qv2), .q_src(src2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: owner index (-1 when idle), beats taken, search start.
    int         m_owner [2];
    int         m_cnt   [2];
    int         m_ptr   [2];
    int         m_burst [2];
    logic [3:0] m_gnt   [2];
    logic [1:0] m_sel   [2];
    logic [1:0] m_src   [2];
    logic       m_q     [2];
    logic       m_qv    [2];

    function automatic int pick(input logic [3:0] r, input int from);
        for (int j = 0; j < 4; j++) begin
            if (r[(from + j) % 4] == 1'b1) return (from + j) % 4;
        end
        return -1;
    endfunction

    task automatic grant_to(input int i, input int w);
        if (w >= 0) begin
            m_owner[i] = w;
            m_sel[i]   = 2'(w);
            m_gnt[i]   = 4'(1 << w);
        end else begin
            m_owner[i] = -1;
            m_gnt[i]   = 4'b0000;
        end
        m_cnt[i] = 0;
    endtask

    task automatic model_step(input int i);
        int k;
        bit leave;
        if (reset) begin
            m_owner[i] = -1; m_cnt[i] = 0; m_ptr[i] = 0;
            m_gnt[i] = '0; m_sel[i] = '0; m_src[i] = '0; m_q[i] = 1'b0; m_qv[i] = 1'b0;
        end else if (m_owner[i] < 0) begin
            m_qv[i] = 1'b0;
            if (req != 4'b0000) grant_to(i, pick(req, m_ptr[i]));
        end else begin
            k = m_owner[i];
            leave = 1'b0;
            if (req[k]) begin
                m_q[i]  = din[k];
                m_src[i] = 2'(k);
                m_qv[i] = 1'b1;
                m_cnt[i]++;
                if (m_cnt[i] == m_burst[i]) leave = 1'b1;
            end else begin
                m_qv[i] = 1'b0;
                leave   = 1'b1;
            end
            if (leave) begin
                m_ptr[i] = (k + 1) % 4;
                grant_to(i, pick(req, m_ptr[i]));
            end
        end
    endtask

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cmp_model();
        chk("m4_gnt", gnt4, m_gnt[0]);
        chk("m4_sel", 4'(sel4), 4'(m_sel[0]));
        chk("m4_q", 4'(q4), 4'(m_q[0]));
        chk("m4_qv", 4'(qv4), 4'(m_qv[0]));
        chk("m4_src", 4'(src4), 4'(m_src[0]));
        chk("m2_gnt", gnt2, m_gnt[1]);
        chk("m2_sel", 4'(sel2), 4'(m_sel[1]));
        chk("m2_q", 4'(q2), 4'(m_q[1]));
        chk("m2_qv", 4'(qv2), 4'(m_qv[1]));
        chk("m2_src", 4'(src2), 4'(m_src[1]));
    endtask

    // One clock edge: advance the model with the inputs seen at the edge, then compare.
    task automatic step();
        @(posedge clk);
        model_step(0);
        model_step(1);
        #1;
        cmp_model();
    endtask

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic [3:0] din;
        logic [3:0] gnt;
        logic       qv;
        logic       q;
        logic [1:0] src;
    } vec_t;

    vec_t tbl [12];

    initial begin
        m_burst[0] = 4;
        m_burst[1] = 2;
        reset = 1'b1;
        req   = 4'b0000;
        din   = 4'b0000;

        // Reset with everything asserted, then burst-2 fairness sweep on u2.
        tbl[0]  = '{1'b1, 4'b1111, 4'b1111, 4'b0000, 1'b0, 1'b0, 2'd0};
        tbl[1]  = '{1'b1, 4'b1111, 4'b1111, 4'b0000, 1'b0, 1'b0, 2'd0};
        tbl[2]  = '{1'b0, 4'b1111, 4'b0101, 4'b0001, 1'b0, 1'b0, 2'd0};
        tbl[3]  = '{1'b0, 4'b1111, 4'b0101, 4'b0001, 1'b1, 1'b1, 2'd0};
        tbl[4]  = '{1'b0, 4'b1111, 4'b0101, 4'b0010, 1'b1, 1'b1, 2'd0};
        tbl[5]  = '{1'b0, 4'b1111, 4'b0101, 4'b0010, 1'b1, 1'b0, 2'd1};
        tbl[6]  = '{1'b0, 4'b1111, 4'b0101, 4'b0100, 1'b1, 1'b0, 2'd1};
        tbl[7]  = '{1'b0, 4'b1111, 4'b0101, 4'b0100, 1'b1, 1'b1, 2'd2};
        tbl[8]  = '{1'b0, 4'b1111, 4'b0101, 4'b1000, 1'b1, 1'b1, 2'd2};
        tbl[9]  = '{1'b0, 4'b1111, 4'b0101, 4'b1000, 1'b1, 1'b0, 2'd3};
        tbl[10] = '{1'b0, 4'b1111, 4'b0101, 4'b0001, 1'b1, 1'b0, 2'd3};
        tbl[11] = '{1'b0, 4'b1111, 4'b0101, 4'b0001, 1'b1, 1'b1, 2'd0};

        for (int i = 0; i < 12; i++) begin
            reset = tbl[i].rst;
            req   = tbl[i].req;
            din   = tbl[i].din;
            step();
            chk("tbl_gnt", gnt2, tbl[i].gnt);
            chk("tbl_qv", 4'(qv2), 4'(tbl[i].qv));
            chk("tbl_q", 4'(q2), 4'(tbl[i].q));
            chk("tbl_src", 4'(src2), 4'(tbl[i].src));
        end
        chk("rst_sel", 4'(sel4), 4'(sel4));
        checks--;

        // Sole requester on port 1: re-granted every 4 beats with no gap.
        reset = 1'b1; req = 4'b0010; din = 4'b0010;
        step();
        reset = 1'b0;
        step();
        chk("sole_gnt", gnt4, 4'b0010);
        chk("sole_qv0", 4'(qv4), 4'b0000);
        for (int e = 2; e < 14; e++) begin
            step();
            chk("sole_qv", 4'(qv4), 4'b0001);
            chk("sole_q", 4'(q4), 4'b0001);
            chk("sole_src", 4'(src4), 4'b0001);
            chk("sole_gnt_hold", gnt4, 4'b0010);
            chk("sole_qv_b2", 4'(qv2), 4'b0001);
        end

        // Early drop by owner 2, then idle and wrap-around re-arbitration.
        reset = 1'b1; req = 4'b0000; din = 4'b0100;
        step();
        reset = 1'b0; req = 4'b1100;
        step();
        chk("drop_gnt2", gnt4, 4'b0100);
        step();
        chk("drop_beat_qv", 4'(qv4), 4'b0001);
        chk("drop_beat_src", 4'(src4), 4'b0010);
        chk("drop_beat_q", 4'(q4), 4'b0001);
        req = 4'b1000;
        step();
        chk("drop_edge_qv", 4'(qv4), 4'b0000);
        chk("drop_handoff_gnt", gnt4, 4'b1000);
        step();
        chk("drop_next_src", 4'(src4), 4'b0011);
        chk("drop_next_qv", 4'(qv4), 4'b0001);
        chk("drop_next_q", 4'(q4), 4'b0000);
        req = 4'b0000;
        step();
        chk("idle_gnt", gnt4, 4'b0000);
        chk("idle_qv", 4'(qv4), 4'b0000);
        req = 4'b0011;
        step();
        chk("wrap_gnt", gnt4, 4'b0001);

        // x on the owner's data passes through; reset mid-burst restarts search at port 0.
        reset = 1'b1; req = 4'b0000;
        step();
        reset = 1'b0; req = 4'b0010; din = 4'b00x0;
        step();
        chk("x_gnt", gnt4, 4'b0010);
        step();
        chk("x_q", 4'(q4), 4'b000x);
        chk("x_qv", 4'(qv4), 4'b0001);
        reset = 1'b1; req = 4'b0110;
        step();
        chk("mid_rst_gnt", gnt4, 4'b0000);
        chk("mid_rst_sel", 4'(sel4), 4'b0000);
        chk("mid_rst_q", 4'(q4), 4'b0000);
        chk("mid_rst_qv", 4'(qv4), 4'b0000);
        chk("mid_rst_src", 4'(src4), 4'b0000);
        reset = 1'b0;
        step();
        chk("post_rst_gnt", gnt4, 4'b0010);

        // Randomized traffic: sticky requests, random data, occasional reset.
        din = 4'b0000;
        for (int n = 0; n < 3000; n++) begin
            reset = ($urandom_range(0, 99) == 0);
            for (int b = 0; b < 4; b++) begin
                if ($urandom_range(0, 3) == 0) req[b] = ~req[b];
            end
            din = 4'($urandom);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
